// File: rtl/rr_mux_nx1.sv
// rr_mux_nx1: N-input, WIDTH-bit selector with valid/ready handshakes on
// every channel and a registered output stage. Round-robin arbitration among
// valid inputs, or a static select of one channel when fixed_en is set.
module rr_mux_nx1 #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    fixed_en,
  input  logic [SEL_W-1:0]        fixed_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic              load_en;
  logic              transfer;
  logic              grant_any;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_IN-1:0] grant;
  logic [WIDTH-1:0]  grant_data;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_sel_q;

  // Output register may be (re)loaded when empty or being drained this cycle.
  assign load_en  = !out_valid_q || out_ready;
  assign transfer = grant_any && load_en;

  // Pick the granted channel index: fixed select, or first valid from rr_ptr upward.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (fixed_en) begin
      // Compare against each legal index so fixed_sel >= NUM_IN never grants.
      for (int i = 0; i < NUM_IN; i++) begin
        if (fixed_sel == SEL_W'(i) && in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Walk offsets from highest to lowest so the nearest valid channel wins.
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= int'(NUM_IN)) idx = idx - int'(NUM_IN);
        if (in_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  // Decode the granted index to a one-hot vector and select its data.
  always_comb begin
    grant      = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_any && grant_idx == SEL_W'(i)) begin
        grant[i]   = 1'b1;
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = grant & {NUM_IN{load_en}};

  // Advance the round-robin pointer past the winner; fixed mode leaves it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer && !fixed_en) begin
      if (grant_idx == SEL_W'(NUM_IN - 1)) rr_ptr_d = '0;
      else                                 rr_ptr_d = grant_idx + 1'b1;
    end
  end

  // State registers: pointer and output stage; data/sel hold when nothing loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (load_en) begin
        out_valid_q <= grant_any;
        if (grant_any) begin
          out_data_q <= grant_data;
          out_sel_q  <= grant_idx;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Bench for rr_mux_nx1: a 4-input instance driven with directed vectors and a
// 3-input instance driven with a random soak. Expected words are queued by the
// driver and popped by per-instance monitors when the output handshakes.
module tb_rr_mux_nx1;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] sel;
  } exp_t;

  logic        clk;
  logic        rst;
  // 4-input instance
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        fixed_en;
  logic [1:0]  fixed_sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_sel;
  logic        out_ready;
  // 3-input instance
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        fixed_en3;
  logic [1:0]  fixed_sel3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_sel3;
  logic        out_ready3;

  exp_t q4[$];
  exp_t q3[$];
  int   errors = 0;
  int   checks = 0;

  rr_mux_nx1 #(.WIDTH(8), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fixed_en(fixed_en), .fixed_sel(fixed_sel), .out_data(out_data), .out_valid(out_valid),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  rr_mux_nx1 #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .fixed_en(fixed_en3), .fixed_sel(fixed_sel3), .out_data(out_data3),
    .out_valid(out_valid3), .out_sel(out_sel3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [7:0] d, input logic [1:0] s);
    q4.push_back(exp_t'({d, s}));
  endtask

  // Monitor for the 4-input instance: a word leaves on each output handshake.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL mon4_extra: got data=%h sel=%0d expected no word", out_data, out_sel);
      end else begin
        e = q4.pop_front();
        if (out_data !== e.data || out_sel !== e.sel) begin
          errors++;
          $display("FAIL mon4_word: got data=%h sel=%0d expected data=%h sel=%0d",
                   out_data, out_sel, e.data, e.sel);
        end
      end
    end
  end

  // Monitor for the 3-input instance, plus the out-of-range select guard.
  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst && out_valid3) begin
      checks++;
      if (out_sel3 == 2'd3) begin
        errors++;
        $display("FAIL mon3_sel_range: got sel=%0d expected sel<3", out_sel3);
      end
    end
    if (!rst && out_valid3 && out_ready3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL mon3_extra: got data=%h sel=%0d expected no word", out_data3, out_sel3);
      end else begin
        e = q3.pop_front();
        if (out_data3 !== e.data || out_sel3 !== e.sel) begin
          errors++;
          $display("FAIL mon3_word: got data=%h sel=%0d expected data=%h sel=%0d",
                   out_data3, out_sel3, e.data, e.sel);
        end
      end
    end
  end

  initial begin : driver
    int   m_ptr, g, j;
    bit   ga, m_ov, load;
    logic [2:0] exp_rdy;

    rst = 1'b1;
    in_data = '0; in_valid = '0; fixed_en = 1'b0; fixed_sel = '0; out_ready = 1'b0;
    in_data3 = '0; in_valid3 = '0; fixed_en3 = 1'b0; fixed_sel3 = '0; out_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'h00);
    chk("reset_sel", 32'(out_sel), 32'd0);
    rst = 1'b0;

    // Fairness: all valid, consumer always ready.
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("fair_ready0", 32'(in_ready), 32'b0001);
    push4(8'h11, 2'd0); push4(8'h22, 2'd1); push4(8'h33, 2'd2);
    push4(8'h44, 2'd3); push4(8'h11, 2'd0);
    repeat (5) step();
    in_valid = 4'b0000;
    step();

    // Skip and wrap: bring rr_ptr to 2 via channel 1, then only 3 and 1 valid.
    in_valid = 4'b0010;
    push4(8'h22, 2'd1);
    step();
    in_valid = 4'b1010;
    #1;
    chk("skip_ready", 32'(in_ready), 32'b1000);
    push4(8'h44, 2'd3); push4(8'h22, 2'd1); push4(8'h44, 2'd3);
    repeat (3) step();
    in_valid = 4'b0000;
    step();

    // Backpressure: load channel 0 with out_ready low, then stall five cycles.
    in_valid = 4'b1111;
    out_ready = 1'b0;
    push4(8'h11, 2'd0);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h11);
      chk("stall_sel", 32'(out_sel), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("drain_load_ready", 32'(in_ready), 32'b0010);
    push4(8'h22, 2'd1); push4(8'h33, 2'd2);
    repeat (2) step();
    in_valid = 4'b0000;
    step();

    // Fixed mode on channel 2, then channel 2 drops out.
    fixed_en = 1'b1;
    fixed_sel = 2'd2;
    in_valid = 4'b1111;
    #1;
    chk("fixed_ready", 32'(in_ready), 32'b0100);
    push4(8'h33, 2'd2); push4(8'h33, 2'd2); push4(8'h33, 2'd2);
    repeat (3) step();
    in_valid = 4'b1011;
    #1;
    chk("fixed_noval_ready", 32'(in_ready), 32'd0);
    step();
    chk("fixed_noval_valid", 32'(out_valid), 32'd0);

    // Back to round-robin: pointer retained at 3 from before the fixed period.
    fixed_en = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk("resume_ready", 32'(in_ready), 32'b1000);
    push4(8'h44, 2'd3); push4(8'h11, 2'd0);
    repeat (2) step();
    in_valid = 4'b0000;
    step();

    // Reset mid-stream while a word is held.
    in_valid = 4'b1111;
    out_ready = 1'b0;
    step();
    chk("prerst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'h00);
    chk("midrst_sel", 32'(out_sel), 32'd0);
    step();
    rst = 1'b0;
    in_valid = 4'b1100;
    out_ready = 1'b1;
    push4(8'h33, 2'd2);
    step();
    in_valid = 4'b0000;
    step();

    // Random soak on the 3-input instance against a reference arbiter.
    m_ptr = 0;
    m_ov  = 1'b0;
    for (int c = 0; c < 256; c++) begin
      in_valid3  = 3'($urandom);
      out_ready3 = 1'($urandom_range(0, 1));
      fixed_en3  = ($urandom_range(0, 3) == 0);
      fixed_sel3 = 2'($urandom);
      in_data3   = 24'($urandom);
      ga = 1'b0;
      g  = 0;
      if (fixed_en3) begin
        if (fixed_sel3 != 2'd3 && in_valid3[fixed_sel3]) begin
          ga = 1'b1;
          g  = int'(fixed_sel3);
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          j = (m_ptr + k) % 3;
          if (!ga && in_valid3[j]) begin
            ga = 1'b1;
            g  = j;
          end
        end
      end
      load = !m_ov || out_ready3;
      exp_rdy = (load && ga) ? (3'b001 << g) : 3'b000;
      #1;
      chk("soak_ready", 32'(in_ready3), 32'(exp_rdy));
      if (load && ga) begin
        q3.push_back(exp_t'({in_data3[g*8 +: 8], 2'(g)}));
        if (!fixed_en3) m_ptr = (g + 1) % 3;
      end
      if (load) m_ov = ga;
      step();
    end
    in_valid3  = 3'b000;
    out_ready3 = 1'b1;

    for (int w = 0; w < 20 && (q4.size() != 0 || q3.size() != 0); w++) step();
    step();
    chk("q4_empty", 32'(q4.size()), 32'd0);
    chk("q3_empty", 32'(q3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
